vram_arbiter: RTL and testbench

Shares one single-port pixel memory between two requesters: the display scan-out fetcher and the GPU drawing engine. Sits between those masters and the memory macro. Issues at most one access per cycle and gives the display port priority, with an optional starvation guard for the GPU. Tracks in-flight reads through a fixed-latency pipe so each read response is returned to the master that issued it.

---
 rtl/vram_arbiter.sv | 147 ++++++++++++++
 tb/tb_vram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port pixel memory between display scan-out and the GPU.
// Optional GPU starvation guard: define VRAM_ARB_STARVE_EN.
module vram_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 3,
    parameter int RD_LAT     = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              gpu_req,
    input  logic              gpu_we,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [DATA_W-1:0] gpu_wdata,
    output logic              gpu_gnt,
    output logic              gpu_rvalid,
    output logic [DATA_W-1:0] gpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        o_dbg_state
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DISP  = 2'd1;
    localparam logic [1:0] ST_GPU   = 2'd2;
    localparam logic       OWN_DISP = 1'b0;
    localparam logic       OWN_GPU  = 1'b1;

    logic              w_disp_gnt;
    logic              w_gpu_gnt;
    logic              w_force;
    logic              w_ret_v;
    logic              w_ret_o;
    logic [1:0]        r_state;
    logic              r_mem_en;
    logic              r_mem_we;
    logic              r_mem_owner;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [RD_LAT-1:0] r_tag_v;
    logic [RD_LAT-1:0] r_tag_o;
    logic              r_disp_rvalid;
    logic              r_gpu_rvalid;
    logic [DATA_W-1:0] r_disp_rdata;
    logic [DATA_W-1:0] r_gpu_rdata;

`ifdef VRAM_ARB_STARVE_EN
    logic [3:0] r_starve;

    assign w_force = (r_starve == 4'(MAX_STARVE));

    // Counts display wins against a waiting GPU; any GPU grant or withdrawn request restarts it.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (!gpu_req || w_gpu_gnt) begin
            r_starve <= '0;
        end else if (disp_req && w_disp_gnt) begin
            r_starve <= r_starve + 4'd1;
        end
    end
`else
    // Strict display priority: a legal limit (1..15) never forces the GPU.
    assign w_force = (MAX_STARVE == 0);
`endif

    // Grants are held low while reset is asserted so every output reads 0.
    assign w_disp_gnt = rst && disp_req && !(gpu_req && w_force);
    assign w_gpu_gnt  = rst && gpu_req && (!disp_req || w_force);

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_owner <= OWN_DISP;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state  <= w_disp_gnt ? ST_DISP : (w_gpu_gnt ? ST_GPU : ST_IDLE);
            r_mem_en <= w_disp_gnt || w_gpu_gnt;
            r_mem_we <= w_gpu_gnt && gpu_we;
            if (w_disp_gnt || w_gpu_gnt) begin
                r_mem_owner <= w_gpu_gnt ? OWN_GPU : OWN_DISP;
                r_mem_addr  <= w_gpu_gnt ? gpu_addr : disp_addr;
            end
            if (w_gpu_gnt) begin
                r_mem_wdata <= gpu_wdata;
            end
        end
    end

    // Tag pipe entered from the command register; its last stage lines up with valid mem_rdata.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_tag_v <= '0;
            r_tag_o <= '0;
        end else begin
            r_tag_v[0] <= r_mem_en && !r_mem_we;
            r_tag_o[0] <= r_mem_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_o[i] <= r_tag_o[i-1];
            end
        end
    end

    assign w_ret_v = r_tag_v[RD_LAT-1];
    assign w_ret_o = r_tag_o[RD_LAT-1];

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_disp_rvalid <= 1'b0;
            r_gpu_rvalid  <= 1'b0;
            r_disp_rdata  <= '0;
            r_gpu_rdata   <= '0;
        end else begin
            r_disp_rvalid <= w_ret_v && (w_ret_o == OWN_DISP);
            r_gpu_rvalid  <= w_ret_v && (w_ret_o == OWN_GPU);
            if (w_ret_v && (w_ret_o == OWN_DISP)) begin
                r_disp_rdata <= mem_rdata;
            end
            if (w_ret_v && (w_ret_o == OWN_GPU)) begin
                r_gpu_rdata <= mem_rdata;
            end
        end
    end

    assign disp_gnt    = w_disp_gnt;
    assign gpu_gnt     = w_gpu_gnt;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign disp_rvalid = r_disp_rvalid;
    assign disp_rdata  = r_disp_rdata;
    assign gpu_rvalid  = r_gpu_rvalid;
    assign gpu_rdata   = r_gpu_rdata;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share stimulus, each with its own memory.
module tb_vram_arbiter;
    typedef struct {
        logic       dr;
        logic [7:0] da;
        logic       gr;
        logic       gwe;
        logic [7:0] ga;
        logic [2:0] gwd;
        logic       edg;
        logic       egg;
        logic [2:0] erd;
    } vec_t;

`ifdef VRAM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic       rst;
    logic       disp_req;
    logic [7:0] disp_addr;
    logic       gpu_req;
    logic       gpu_we;
    logic [7:0] gpu_addr;
    logic [2:0] gpu_wdata;

    logic       dg1, gg1, drv1, grv1, men1, mwe1;
    logic [2:0] drd1, grd1, mwd1, mrd1;
    logic [7:0] ma1;
    logic [1:0] st1;
    logic       dg3, gg3, drv3, grv3, men3, mwe3;
    logic [2:0] drd3, grd3, mwd3, mrd3;
    logic [7:0] ma3;
    logic [1:0] st3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2:0]  mem1 [256];
    logic [2:0]  mem3 [256];
    logic [2:0]  rp1;
    logic [2:0]  rp3 [3];
    logic [19:0] exp_q1 [$];
    logic [19:0] exp_q3 [$];
    logic [7:0]  exp_addr;
    logic [2:0]  exp_wdata;
    logic [1:0]  exp_state;
    logic [2:0]  last_d [2];
    logic [2:0]  last_g [2];
    vec_t        tbl [8];

    vram_arbiter #(.ADDR_W(8), .DATA_W(3), .RD_LAT(1), .MAX_STARVE(4)) u_dut1 (
        .sysclk(sysclk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(dg1),
        .disp_rvalid(drv1), .disp_rdata(drd1),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
        .gpu_gnt(gg1), .gpu_rvalid(grv1), .gpu_rdata(grd1),
        .mem_en(men1), .mem_we(mwe1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_rdata(mrd1),
        .o_dbg_state(st1)
    );

    vram_arbiter #(.ADDR_W(8), .DATA_W(3), .RD_LAT(3), .MAX_STARVE(4)) u_dut3 (
        .sysclk(sysclk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(dg3),
        .disp_rvalid(drv3), .disp_rdata(drd3),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
        .gpu_gnt(gg3), .gpu_rvalid(grv3), .gpu_rdata(grd3),
        .mem_en(men3), .mem_we(mwe3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_rdata(mrd3),
        .o_dbg_state(st3)
    );

    // Memory contents start as addr[2:0] ^ 3'b101.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] <= 3'(i) ^ 3'b101;
            mem3[i] <= 3'(i) ^ 3'b101;
        end
    end

    always @(posedge sysclk) begin
        if (men1 && mwe1) mem1[ma1] <= mwd1;
        rp1 <= mem1[ma1];
    end

    always @(posedge sysclk) begin
        if (men3 && mwe3) mem3[ma3] <= mwd3;
        rp3[0] <= mem3[ma3];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    assign mrd1 = rp1;
    assign mrd3 = rp3[2];

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Entry: {response cycle, owner (1=gpu), data}.
    task automatic push(input logic owner, input logic [2:0] data);
        exp_q1.push_back({16'(cyc + 3), owner, data});
        exp_q3.push_back({16'(cyc + 5), owner, data});
    endtask

    task automatic mon(input int k, input logic dv, input logic gv,
                       input logic [2:0] dd, input logic [2:0] gd);
        logic [19:0] e;
        logic        have_e;
        have_e = 1'b0;
        e      = '0;
        if (dv || gv) begin
            if ((k == 0) ? (exp_q1.size() == 0) : (exp_q3.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL rvalid_unexpected dut%0d: disp_rvalid=%0b gpu_rvalid=%0b, expected no response (cycle %0d)",
                         k, dv, gv, cyc);
            end else begin
                e      = (k == 0) ? exp_q1.pop_front() : exp_q3.pop_front();
                have_e = 1'b1;
                chk((k == 0) ? "resp_lat1" : "resp_lat3",
                    32'({cyc[15:0], gv, dv, (gv ? gd : dd)}),
                    32'({e[19:4], e[3], ~e[3], e[2:0]}));
            end
        end
        if (!dv) chk("disp_rdata_hold", 32'(dd), 32'(last_d[k]));
        if (!gv) chk("gpu_rdata_hold", 32'(gd), 32'(last_g[k]));
        if (dv) last_d[k] = have_e ? e[2:0] : dd;
        if (gv) last_g[k] = have_e ? e[2:0] : gd;
    endtask

    always @(negedge sysclk) begin
        if (rst) begin
            mon(0, drv1, grv1, drd1, grd1);
            mon(1, drv3, grv3, drd3, grd3);
        end else begin
            last_d[0] = '0; last_d[1] = '0;
            last_g[0] = '0; last_g[1] = '0;
        end
    end

    function automatic vec_t mk(input logic dr, input logic [7:0] da, input logic gr,
                                input logic gwe, input logic [7:0] ga, input logic [2:0] gwd,
                                input logic edg, input logic egg, input logic [2:0] erd);
        vec_t v;
        v = '{dr, da, gr, gwe, ga, gwd, edg, egg, erd};
        return v;
    endfunction

    // One request cycle: drive at negedge, check grants, then check the command register.
    task automatic apply(input vec_t v);
        @(negedge sysclk);
        disp_req  = v.dr;
        disp_addr = v.da;
        gpu_req   = v.gr;
        gpu_we    = v.gwe;
        gpu_addr  = v.ga;
        gpu_wdata = v.gwd;
        #1;
        chk("disp_gnt", 32'({dg3, dg1}), 32'({2{v.edg}}));
        chk("gpu_gnt", 32'({gg3, gg1}), 32'({2{v.egg}}));
        if (v.edg) push(1'b0, v.erd);
        else if (v.egg && !v.gwe) push(1'b1, v.erd);
        if (v.edg) exp_addr = v.da;
        else if (v.egg) begin
            exp_addr  = v.ga;
            exp_wdata = v.gwd;
        end
        exp_state = v.edg ? 2'd1 : (v.egg ? 2'd2 : 2'd0);
        @(posedge sysclk);
        #1;
        chk("mem_cmd_lat1", 32'({men1, mwe1, ma1, mwd1}), 32'({v.edg | v.egg, v.egg & v.gwe, exp_addr, exp_wdata}));
        chk("mem_cmd_lat3", 32'({men3, mwe3, ma3, mwd3}), 32'({v.edg | v.egg, v.egg & v.gwe, exp_addr, exp_wdata}));
        chk("dbg_state", 32'({st3, st1}), 32'({2{exp_state}}));
        disp_req = 1'b0;
        gpu_req  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic check_reset_zero();
        chk("reset_outputs_lat1", 32'({dg1, gg1, drv1, grv1, drd1, grd1, men1, mwe1, ma1, mwd1, st1}), 32'd0);
        chk("reset_outputs_lat3", 32'({dg3, gg3, drv3, grv3, drd3, grd3, men3, mwe3, ma3, mwd3, st3}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // dr da gr we ga gwd -> disp_gnt gpu_gnt read_data
        tbl[0] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'b000);
        tbl[1] = mk(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b101);
        tbl[2] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 3'd6, 1'b0, 1'b1, 3'b000);
        tbl[3] = mk(1'b1, 8'h11, 1'b1, 1'b0, 8'h31, 3'd2, 1'b1, 1'b0, 3'b100);
        tbl[4] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'b000);
        tbl[5] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h32, 3'd1, 1'b0, 1'b1, 3'b111);
        tbl[6] = mk(1'b1, 8'hFF, 1'b1, 1'b1, 8'h33, 3'd7, 1'b1, 1'b0, 3'b010);
        tbl[7] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'b000);

        rst       = 1'b0;
        disp_req  = 1'b1;
        disp_addr = 8'hA5;
        gpu_req   = 1'b1;
        gpu_we    = 1'b1;
        gpu_addr  = 8'h5A;
        gpu_wdata = 3'b111;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_state = '0;
        idle(2);
        #1;
        check_reset_zero();
        @(negedge sysclk);
        disp_req = 1'b0;
        gpu_req  = 1'b0;
        rst      = 1'b1;
        idle(2);

        for (int i = 0; i < 8; i++) apply(tbl[i]);
        idle(6);

        // GPU write then display read of the same address.
        apply(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 3'b011, 1'b0, 1'b1, 3'b000));
        apply(mk(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'b011));

        // Alternating reads, one per cycle.
        apply(mk(1'b1, 8'h60, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b101));
        apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h61, 3'd0, 1'b0, 1'b1, 3'b100));
        apply(mk(1'b1, 8'h62, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b111));
        apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h63, 3'd0, 1'b0, 1'b1, 3'b110));
        apply(mk(1'b1, 8'h64, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b001));
        apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h65, 3'd0, 1'b0, 1'b1, 3'b000));
        idle(6);

        // Both masters request continuously.
        for (int i = 0; i < 10; i++) begin
            logic g;
            g = STARVE_EN && ((i % 5) == 4);
            apply(mk(1'b1, 8'h50, 1'b1, 1'b0, 8'h40, 3'd0, !g, g, 3'b101));
        end
        idle(1);

        // GPU request withdrawn while display holds the bus; the guard must start over.
        for (int i = 0; i < 9; i++) begin
            logic gr;
            logic g;
            gr = (i != 3);
            g  = STARVE_EN && (i == 8);
            apply(mk(1'b1, 8'h51, gr, 1'b0, 8'h41, 3'd0, !g, g, 3'b100));
        end
        idle(8);
        chk("pending_before_reset", 32'(exp_q1.size() + exp_q3.size()), 32'd0);

        // Reset with two reads in flight.
        apply(mk(1'b1, 8'h70, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b101));
        apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h71, 3'd0, 1'b0, 1'b1, 3'b100));
        rst = 1'b0;
        exp_q1.delete();
        exp_q3.delete();
        disp_req = 1'b1;
        gpu_req  = 1'b1;
        @(negedge sysclk);
        #1;
        check_reset_zero();
        @(negedge sysclk);
        disp_req  = 1'b0;
        gpu_req   = 1'b0;
        rst       = 1'b1;
        exp_addr  = '0;
        exp_wdata = '0;
        idle(8);

        apply(mk(1'b1, 8'h72, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b111));
        idle(8);
        chk("pending_at_end", 32'(exp_q1.size() + exp_q3.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
